// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - SPI write-frame serializer for an MCP49x1-class DAC with LDAC strobe
//
// Accepts one DDS sample per frame through a valid/ready handshake, shifts the
// 16-bit word {0, BUF, GA_N, SHDN_n=1, sample, zero pad} out MSB first in SPI
// mode 0, then deasserts chip select and pulses LDAC_n to latch the output.
//
// Ports:
//   clk_i           system clock, all state updates on posedge
//   rst_i           synchronous active-high reset
//   sample_in_i     unsigned sample code, DAC_N bits
//   sample_valid_i  sample_in_i holds a valid sample
//   sample_ready_o  block can accept a sample (IDLE only)
//   spi_cs_n_o      DAC chip select, active low
//   spi_sclk_o      SPI clock, idles low
//   spi_sdi_o       SPI data, changes while sclk is low
//   dac_ldac_n_o    DAC latch strobe, active low
//   frame_done_o    one-cycle pulse when LDAC_n returns high

module dac_spi_tx #(
    parameter int DAC_N   = 10,
    parameter int CLK_DIV = 4,
    parameter bit BUF     = 1'b0,
    parameter bit GA_N    = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DAC_N-1:0] sample_in_i,
    input  logic             sample_valid_i,
    output logic             sample_ready_o,
    output logic             spi_cs_n_o,
    output logic             spi_sclk_o,
    output logic             spi_sdi_o,
    output logic             dac_ldac_n_o,
    output logic             frame_done_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD,
        S_CSHI,
        S_LDAC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          ready_q, ready_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic          sdi_q, sdi_d;
    logic          ldac_n_q, ldac_n_d;
    logic          done_q, done_d;

    logic [11:0]   data_field;
    logic [15:0]   frame_word;
    logic          cyc_last;

    // Sample is left-justified in the 12-bit data field; unused LSBs are zero.
    assign data_field = 12'(sample_in_i) << (12 - DAC_N);
    assign frame_word = {1'b0, BUF, GA_N, 1'b1, data_field};
    assign cyc_last   = (cyc_q == CYC_LAST);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        ready_d  = 1'b0;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        sdi_d    = sdi_q;
        ldac_n_d = 1'b1;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                if (sample_valid_i && ready_q) begin
                    state_d = S_SHIFT;
                    ready_d = 1'b0;
                    cs_n_d  = 1'b0;
                    shreg_d = frame_word;
                    sdi_d   = frame_word[15];
                    bit_d   = 4'd15;
                    cyc_d   = '0;
                end
            end
            S_SHIFT: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_last) begin
                    cyc_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: either finish or present the next bit.
                        sclk_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_d   = bit_q - 4'd1;
                            shreg_d = {shreg_q[14:0], 1'b0};
                            sdi_d   = shreg_q[14];
                        end
                    end
                end
            end
            S_HOLD: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_last) begin
                    cyc_d   = '0;
                    state_d = S_CSHI;
                    cs_n_d  = 1'b1;
                    sdi_d   = 1'b0;
                end
            end
            S_CSHI: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_last) begin
                    cyc_d    = '0;
                    state_d  = S_LDAC;
                    ldac_n_d = 1'b0;
                end
            end
            S_LDAC: begin
                cyc_d    = cyc_q + 1'b1;
                ldac_n_d = 1'b0;
                if (cyc_last) begin
                    cyc_d    = '0;
                    state_d  = S_IDLE;
                    ldac_n_d = 1'b1;
                    ready_d  = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            bit_q    <= 4'd0;
            shreg_q  <= 16'd0;
            ready_q  <= 1'b1;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            sdi_q    <= 1'b0;
            ldac_n_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            ready_q  <= ready_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            sdi_q    <= sdi_d;
            ldac_n_q <= ldac_n_d;
            done_q   <= done_d;
        end
    end

    // ready_q already holds its post-reset value while rst_i is high; masking
    // keeps the source from seeing ready until reset is released.
    assign sample_ready_o = ready_q & ~rst_i;
    assign spi_cs_n_o     = cs_n_q;
    assign spi_sclk_o     = sclk_q;
    assign spi_sdi_o      = sdi_q;
    assign dac_ldac_n_o   = ldac_n_q;
    assign frame_done_o   = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - scoreboard bench for dac_spi_tx at CLK_DIV=4 and CLK_DIV=1
module tb_dac_spi_tx;

    localparam int DN = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst    [2];
    logic [DN-1:0] smp    [2];
    logic          vld    [2];
    logic          rdy    [2];
    logic          cs_n   [2];
    logic          sclk   [2];
    logic          sdi    [2];
    logic          ldac_n [2];
    logic          fdone  [2];

    dac_spi_tx #(.DAC_N(DN), .CLK_DIV(4), .BUF(1'b0), .GA_N(1'b1)) u_div4 (
        .clk_i(clk), .rst_i(rst[0]), .sample_in_i(smp[0]), .sample_valid_i(vld[0]),
        .sample_ready_o(rdy[0]), .spi_cs_n_o(cs_n[0]), .spi_sclk_o(sclk[0]),
        .spi_sdi_o(sdi[0]), .dac_ldac_n_o(ldac_n[0]), .frame_done_o(fdone[0])
    );

    dac_spi_tx #(.DAC_N(DN), .CLK_DIV(1), .BUF(1'b0), .GA_N(1'b1)) u_div1 (
        .clk_i(clk), .rst_i(rst[1]), .sample_in_i(smp[1]), .sample_valid_i(vld[1]),
        .sample_ready_o(rdy[1]), .spi_cs_n_o(cs_n[1]), .spi_sclk_o(sclk[1]),
        .spi_sdi_o(sdi[1]), .dac_ldac_n_o(ldac_n[1]), .frame_done_o(fdone[1])
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          inst;
        logic [15:0] word;
        int          t0;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Command nibble 0b0011 (write A, unbuffered, 1x gain, active) then the
    // sample scaled into the 12-bit field.
    function automatic logic [15:0] model_word(input logic [DN-1:0] s);
        return 16'h3000 + 16'(s) * 16'(1 << (12 - DN));
    endfunction

    // Monitor: reconstructs each frame from the SPI pins and compares on frame_done.
    int          nrise     [2];
    int          cs_low    [2];
    int          ldac_low  [2];
    int          last_rise [2];
    logic [15:0] acc       [2];
    logic        psclk     [2];
    logic        psdi      [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                for (int k = exp_q.size() - 1; k >= 0; k--)
                    if (exp_q[k].inst == i) exp_q.delete(k);
                nrise[i] = 0; cs_low[i] = 0; ldac_low[i] = 0;
                acc[i] = 16'd0; psclk[i] = 1'b0; psdi[i] = 1'b0;
            end else begin
                check($sformatf("sclk_while_cs_high[%0d]", i), int'(sclk[i] && cs_n[i]), 0);
                if (psclk[i] && sclk[i])
                    check($sformatf("sdi_stable_high[%0d]", i), int'(sdi[i]), int'(psdi[i]));
                if (!psclk[i] && sclk[i]) begin
                    if (nrise[i] > 0)
                        check($sformatf("sclk_period[%0d]", i), cyc - last_rise[i], 2 * div_of(i));
                    last_rise[i] = cyc;
                    acc[i] = {acc[i][14:0], sdi[i]};
                    nrise[i]++;
                end
                if (!cs_n[i])   cs_low[i]++;
                if (!ldac_n[i]) ldac_low[i]++;
                if (fdone[i]) begin
                    int found;
                    found = -1;
                    for (int k = 0; k < exp_q.size(); k++)
                        if (found < 0 && exp_q[k].inst == i) found = k;
                    if (found < 0) begin
                        check($sformatf("unexpected_frame_done[%0d]", i), 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q[found];
                        exp_q.delete(found);
                        check($sformatf("frame_word[%0d]", i), int'(acc[i]), int'(e.word));
                        check($sformatf("sclk_rises[%0d]", i), nrise[i], 16);
                        check($sformatf("cs_low_cycles[%0d]", i), cs_low[i], 33 * div_of(i));
                        check($sformatf("ldac_low_cycles[%0d]", i), ldac_low[i], div_of(i));
                        check($sformatf("done_latency[%0d]", i), cyc - e.t0, 35 * div_of(i) + 1);
                        check($sformatf("ready_at_done[%0d]", i), int'(rdy[i]), 1);
                    end
                    nrise[i] = 0; cs_low[i] = 0; ldac_low[i] = 0; acc[i] = 16'd0;
                end
                psclk[i] = sclk[i];
                psdi[i]  = sdi[i];
            end
        end
    end

    int last_t0 [2];

    // Present a sample and wait (bounded) for acceptance; returns after the T0 edge.
    task automatic send(input int i, input logic [DN-1:0] s);
        int k;
        smp[i] = s;
        vld[i] = 1'b1;
        for (k = 0; k < 400; k++) begin
            if (rdy[i]) break;
            @(negedge clk);
        end
        check($sformatf("accept_within_bound[%0d]", i), int'(k < 400), 1);
        if (k < 400) begin
            exp_q.push_back('{inst: i, word: model_word(s), t0: cyc});
            last_t0[i] = cyc;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int i, input int n);
        vld[i] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // A new sample and valid pulse while the frame is shifting must be ignored.
    task automatic midpulse(input int i);
        repeat ($urandom_range(1, 100)) @(negedge clk);
        smp[i] = DN'($urandom);
        vld[i] = 1'b1;
        check($sformatf("ready_low_midframe[%0d]", i), int'(rdy[i]), 0);
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    initial begin
        int prev;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b0; smp[i] = '0; last_t0[i] = 0;
        end

        // Reset held 3 cycles
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("ready_during_rst", int'(rdy[i]), 0);
                check("cs_n_during_rst", int'(cs_n[i]), 1);
                check("sclk_during_rst", int'(sclk[i]), 0);
                check("ldac_n_during_rst", int'(ldac_n[i]), 1);
            end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("ready_after_rst", int'(rdy[i]), 1);
            check("cs_n_after_rst", int'(cs_n[i]), 1);
            check("sdi_after_rst", int'(sdi[i]), 0);
            check("done_after_rst", int'(fdone[i]), 0);
        end

        // Single frame
        send(0, 10'h2AA);
        idle(0, 150);

        // Valid held high: back-to-back frames
        send(0, 10'h000);
        prev = last_t0[0];
        send(0, 10'h3FF);
        check("b2b_spacing_1", last_t0[0] - prev, 141);
        prev = last_t0[0];
        send(0, 10'h155);
        check("b2b_spacing_2", last_t0[0] - prev, 141);
        idle(0, 150);

        // Mid-frame sample change and valid pulse
        send(0, DN'($urandom));
        midpulse(0);
        idle(0, 150);

        // Reset during bit 7
        send(0, DN'($urandom));
        idle(0, 66);
        rst[0] = 1'b1;
        @(negedge clk);
        check("abort_cs_n", int'(cs_n[0]), 1);
        check("abort_sclk", int'(sclk[0]), 0);
        check("abort_ldac_n", int'(ldac_n[0]), 1);
        check("abort_done", int'(fdone[0]), 0);
        @(negedge clk);
        rst[0] = 1'b0;
        idle(0, 150);
        send(0, DN'($urandom));
        idle(0, 150);

        // CLK_DIV=1 full-scale frame
        send(1, 10'h3FF);
        idle(1, 40);

        // Randomized traffic, gaps of 0 give back-to-back frames
        for (int n = 0; n < 10; n++) begin
            send(0, DN'($urandom));
            if ($urandom_range(0, 3) == 0) midpulse(0);
            if ($urandom_range(0, 1) == 0) idle(0, $urandom_range(1, 20));
        end
        idle(0, 0);
        for (int n = 0; n < 25; n++) begin
            send(1, DN'($urandom));
            if ($urandom_range(0, 1) == 0) idle(1, $urandom_range(1, 10));
        end
        idle(1, 0);

        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        check("all_frames_completed", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
